// File: rtl/sim_video_out.sv
// Video output stage: palette expansion of indexed pixels, sync/blank alignment,
// and raster timing measurement (line width, active lines, frame count).
module sim_video_out #(
  parameter int unsigned PIX_BITS = 1,
  parameter int unsigned CNT_BITS = 12
) (
  input  logic                clk_sys,
  input  logic                reset_n,
  input  logic                ce_pix,
  input  logic [PIX_BITS-1:0] pixel,
  input  logic                hsync,
  input  logic                vsync,
  input  logic                hblank,
  input  logic                vblank,
  input  logic                pal_wr,
  input  logic [PIX_BITS-1:0] pal_addr,
  input  logic [23:0]         pal_data,
  output logic [7:0]          vga_r,
  output logic [7:0]          vga_g,
  output logic [7:0]          vga_b,
  output logic                vga_hs,
  output logic                vga_vs,
  output logic                vga_hb,
  output logic                vga_vb,
  output logic [CNT_BITS-1:0] line_width,
  output logic [CNT_BITS-1:0] frame_lines,
  output logic [15:0]         frame_count,
  output logic                frame_done
);

  localparam int unsigned PAL_SIZE = 1 << PIX_BITS;
  localparam logic [CNT_BITS-1:0] CNT_MAX = '1;

  logic [23:0]         palette [PAL_SIZE];
  logic [PIX_BITS-1:0] s1_pix;
  logic                s1_hs, s1_vs, s1_hb, s1_vb;
  logic                s1_valid;
  logic                de_prev, vs_prev, armed;
  logic [CNT_BITS-1:0] pix_cnt, line_cnt;

  logic                s1_de_c, line_end_c, frame_edge_c;
  logic [CNT_BITS-1:0] line_cnt_next_c;

  // Edge detection on stage-1 samples; line_cnt_next_c already includes a line ending now
  always_comb begin
    s1_de_c         = ~(s1_hb | s1_vb);
    line_end_c      = de_prev & ~s1_de_c & (pix_cnt != '0);
    frame_edge_c    = s1_vs & ~vs_prev;
    line_cnt_next_c = line_cnt;
    if (line_end_c && (line_cnt != CNT_MAX)) begin
      line_cnt_next_c = line_cnt + CNT_BITS'(1);
    end
  end

  // Palette RAM; reset restores legacy black/white, writes ignored while in reset
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < PAL_SIZE; i++) begin
        palette[PIX_BITS'(i)] <= (i == 0) ? 24'h000000 : 24'hFFFFFF;
      end
    end else if (pal_wr) begin
      palette[pal_addr] <= pal_data;
    end
  end

  // Two-stage pixel pipeline plus timing measurement, both gated by ce_pix
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      s1_pix      <= '0;
      s1_hs       <= 1'b0;
      s1_vs       <= 1'b0;
      s1_hb       <= 1'b0;
      s1_vb       <= 1'b0;
      s1_valid    <= 1'b0;
      vga_r       <= '0;
      vga_g       <= '0;
      vga_b       <= '0;
      vga_hs      <= 1'b0;
      vga_vs      <= 1'b0;
      vga_hb      <= 1'b0;
      vga_vb      <= 1'b0;
      de_prev     <= 1'b0;
      vs_prev     <= 1'b0;
      armed       <= 1'b0;
      pix_cnt     <= '0;
      line_cnt    <= '0;
      line_width  <= '0;
      frame_lines <= '0;
      frame_count <= '0;
      frame_done  <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (ce_pix) begin
        s1_pix   <= pixel;
        s1_hs    <= hsync;
        s1_vs    <= vsync;
        s1_hb    <= hblank;
        s1_vb    <= vblank;
        s1_valid <= 1'b1;
        {vga_r, vga_g, vga_b} <= s1_de_c ? palette[s1_pix] : 24'h000000;
        vga_hs <= s1_hs;
        vga_vs <= s1_vs;
        vga_hb <= s1_hb;
        vga_vb <= s1_vb;
        // The reset contents of stage 1 are not a real sample, so skip measuring them
        if (s1_valid) begin
          de_prev <= s1_de_c;
          vs_prev <= s1_vs;
          if (s1_de_c) begin
            if (pix_cnt != CNT_MAX) pix_cnt <= pix_cnt + CNT_BITS'(1);
          end else begin
            pix_cnt <= '0;
          end
          if (line_end_c) line_width <= pix_cnt;
          if (frame_edge_c) begin
            if (armed) begin
              frame_lines <= line_cnt_next_c;
              frame_count <= frame_count + 16'd1;
              frame_done  <= 1'b1;
            end
            armed    <= 1'b1;
            line_cnt <= '0;
          end else begin
            line_cnt <= line_cnt_next_c;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_sim_video_out.sv
// Bench for sim_video_out: per-clock colour/sync checks against a sample-history
// model, plus directed raster sequences for the timing measurement outputs.
module tb_sim_video_out;
  localparam int unsigned PB = 2;
  localparam int unsigned CB = 12;

  logic          clk_sys = 1'b0;
  logic          reset_n, ce_pix, hsync, vsync, hblank, vblank, pal_wr;
  logic [PB-1:0] pixel, pal_addr;
  logic [23:0]   pal_data;
  logic [7:0]    vga_r, vga_g, vga_b;
  logic          vga_hs, vga_vs, vga_hb, vga_vb, frame_done;
  logic [CB-1:0] line_width, frame_lines;
  logic [15:0]   frame_count;

  always #5 clk_sys = ~clk_sys;

  sim_video_out #(.PIX_BITS(PB), .CNT_BITS(CB)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .ce_pix(ce_pix), .pixel(pixel),
    .hsync(hsync), .vsync(vsync), .hblank(hblank), .vblank(vblank),
    .pal_wr(pal_wr), .pal_addr(pal_addr), .pal_data(pal_data),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .vga_hs(vga_hs), .vga_vs(vga_vs), .vga_hb(vga_hb), .vga_vb(vga_vb),
    .line_width(line_width), .frame_lines(frame_lines),
    .frame_count(frame_count), .frame_done(frame_done)
  );

  // Model: the output after an enable shows the sample taken at the previous enable
  logic [23:0]   pal_m [1 << PB];
  logic [PB-1:0] l_pix;
  logic          l_hs, l_vs, l_hb, l_vb;
  logic [23:0]   e_rgb;
  logic [3:0]    e_sync;
  int checks = 0;
  int passed = 0;
  int fd_seen = 0;
  int base;

  always @(negedge clk_sys) if (frame_done === 1'b1) fd_seen++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    for (int i = 0; i < (1 << PB); i++) pal_m[i] = (i == 0) ? 24'h000000 : 24'hFFFFFF;
    {l_pix, l_hs, l_vs, l_hb, l_vb} = '0;
    e_rgb  = 24'h0;
    e_sync = 4'h0;
  endtask

  task automatic tick();
    @(posedge clk_sys);
    if (!reset_n) model_reset();
    else begin
      if (ce_pix) begin
        e_rgb  = (l_hb | l_vb) ? 24'h000000 : pal_m[l_pix];
        e_sync = {l_hs, l_vs, l_hb, l_vb};
        {l_pix, l_hs, l_vs, l_hb, l_vb} = {pixel, hsync, vsync, hblank, vblank};
      end
      if (pal_wr) pal_m[pal_addr] = pal_data;
    end
    @(negedge clk_sys);
    chk("rgb", 32'({vga_r, vga_g, vga_b}), 32'(e_rgb));
    chk("sync", 32'({vga_hs, vga_vs, vga_hb, vga_vb}), 32'(e_sync));
  endtask

  task automatic pulse_reset();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
  endtask

  task automatic line(input int act, input int blk, input logic vs_blk);
    for (int i = 0; i < act; i++) begin
      pixel = PB'($urandom); hsync = 1'b0; vsync = 1'b0; hblank = 1'b0; vblank = 1'b0;
      tick();
    end
    for (int i = 0; i < blk; i++) begin
      hsync = 1'b1; vsync = vs_blk; hblank = 1'b1; vblank = 1'b0;
      tick();
    end
  endtask

  task automatic vgap();
    for (int i = 0; i < 8; i++) begin
      hsync = 1'b1; vsync = (i < 4); hblank = 1'b1; vblank = 1'b1;
      tick();
    end
  endtask

  task automatic show(input logic [PB-1:0] p, input logic [23:0] exp, input string tag);
    pixel = p; hblank = 1'b0; vblank = 1'b0; ce_pix = 1'b1;
    tick();
    tick();
    chk(tag, 32'({vga_r, vga_g, vga_b}), 32'(exp));
  endtask

  initial begin
    model_reset();
    {ce_pix, hsync, vsync, hblank, vblank, pal_wr} = '0;
    pixel = '0; pal_addr = '0; pal_data = '0;
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    chk("rst_line_width", 32'(line_width), 32'd0);
    chk("rst_frame_lines", 32'(frame_lines), 32'd0);
    chk("rst_frame_count", 32'(frame_count), 32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);

    show(PB'(1), 24'hFFFFFF, "dflt_white");
    show(PB'(0), 24'h000000, "dflt_black");

    // Random traffic: enable every 4th clock, random syncs/blanks and palette writes
    for (int i = 0; i < 400; i++) begin
      ce_pix   = (i % 4 == 0);
      pixel    = PB'($urandom);
      hsync    = 1'($urandom);
      vsync    = 1'($urandom);
      hblank   = ($urandom_range(0, 3) == 0);
      vblank   = ($urandom_range(0, 7) == 0);
      pal_wr   = ($urandom_range(0, 7) == 0);
      pal_addr = PB'($urandom);
      pal_data = 24'($urandom);
      tick();
    end
    pal_wr = 1'b0;

    // Palette write, read-before-write on the lookup edge, blanking to black
    pulse_reset();
    ce_pix = 1'b0; pal_wr = 1'b1; pal_addr = PB'(2); pal_data = 24'h123456;
    tick();
    pal_wr = 1'b0;
    show(PB'(2), 24'h123456, "pal_new");
    pal_wr = 1'b1; pal_data = 24'hABCDEF;
    tick();
    pal_wr = 1'b0;
    chk("rbw_old", 32'({vga_r, vga_g, vga_b}), 32'h123456);
    tick();
    chk("rbw_new", 32'({vga_r, vga_g, vga_b}), 32'hABCDEF);
    hblank = 1'b1;
    tick();
    tick();
    chk("blank_black", 32'({vga_r, vga_g, vga_b}), 32'h0);

    // Three vsync edges around two 160x128 frames
    pulse_reset();
    ce_pix = 1'b1;
    base = fd_seen;
    vgap();
    chk("arm_no_done", 32'(fd_seen - base), 32'd0);
    chk("arm_count", 32'(frame_count), 32'd0);
    repeat (128) line(160, 8, 1'b0);
    vgap();
    chk("f1_lines", 32'(frame_lines), 32'd128);
    chk("f1_width", 32'(line_width), 32'd160);
    chk("f1_count", 32'(frame_count), 32'd1);
    repeat (128) line(160, 8, 1'b0);
    vgap();
    chk("f2_lines", 32'(frame_lines), 32'd128);
    chk("f2_count", 32'(frame_count), 32'd2);
    chk("f2_done_pulses", 32'(fd_seen - base), 32'd2);

    line(5000, 8, 1'b0);
    chk("width_sat", 32'(line_width), 32'd4095);

    // Line end on the same sample as the vsync rise still counts in that frame
    repeat (3) line(10, 4, 1'b0);
    line(10, 4, 1'b1);
    line(0, 4, 1'b0);
    chk("coinc_lines", 32'(frame_lines), 32'd5);
    chk("coinc_width", 32'(line_width), 32'd10);
    chk("coinc_count", 32'(frame_count), 32'd3);

    force dut.frame_count = 16'hFFFF;
    #1;
    release dut.frame_count;
    line(10, 4, 1'b0);
    vgap();
    chk("count_wrap", 32'(frame_count), 32'd0);
    chk("wrap_lines", 32'(frame_lines), 32'd1);

    // Mid-frame reset with a palette write pending during reset
    ce_pix = 1'b0; pal_wr = 1'b1; pal_addr = PB'(0); pal_data = 24'h555555;
    tick();
    ce_pix = 1'b1; pal_wr = 1'b0;
    repeat (5) line(10, 4, 1'b0);
    pixel = PB'(1); hblank = 1'b0; vblank = 1'b0;
    tick();
    pal_wr = 1'b1; pal_addr = PB'(1); pal_data = 24'h000000;
    pulse_reset();
    pal_wr = 1'b0;
    chk("mrst_width", 32'(line_width), 32'd0);
    chk("mrst_lines", 32'(frame_lines), 32'd0);
    chk("mrst_count", 32'(frame_count), 32'd0);
    show(PB'(0), 24'h000000, "mrst_pal0");
    show(PB'(1), 24'hFFFFFF, "mrst_pal1");
    base = fd_seen;
    vgap();
    chk("mrst_arm_only", 32'(fd_seen - base), 32'd0);
    chk("mrst_arm_count", 32'(frame_count), 32'd0);
    repeat (3) line(10, 4, 1'b0);
    vgap();
    chk("mrst_f_count", 32'(frame_count), 32'd1);
    chk("mrst_f_lines", 32'(frame_lines), 32'd3);
    chk("mrst_f_done", 32'(fd_seen - base), 32'd1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/sim_video_out.md
Name: sim_video_out

Overview:
- Parametrised video output stage for the simulation top level.
- Generalises the fixed 1bpp-to-white expansion to PIX_BITS-deep indexed pixels through a runtime-loadable RGB palette.
- Delays sync/blank to stay aligned with colour and forces colour to black while blanked.
- Measures active line width, active line count and frames, so the C++ harness and testbenches can check video timing without decoding the raster.
- Sits between the core's video/sync outputs and the VGA_* pins of the simulation top.

Parameters:
PIX_BITS, 1, pixel index width (1..4); palette has 2**PIX_BITS entries.
CNT_BITS, 12, width of line_width and frame_lines (saturating).

Ports:
clk_sys  in  1  system clock; all logic on rising edge
reset_n  in  1  synchronous active-low reset
ce_pix  in  1  pixel clock enable; pipeline and measurement advance only when high
pixel  in  PIX_BITS  palette index from core
hsync  in  1  core horizontal sync
vsync  in  1  core vertical sync
hblank  in  1  core horizontal blank
vblank  in  1  core vertical blank
pal_wr  in  1  palette write strobe, one clk_sys, independent of ce_pix
pal_addr  in  PIX_BITS  palette entry
pal_data  in  24  {R,G,B} 8 bits each
vga_r  out  8  red
vga_g  out  8  green
vga_b  out  8  blue
vga_hs  out  1  delayed hsync
vga_vs  out  1  delayed vsync
vga_hb  out  1  delayed hblank
vga_vb  out  1  delayed vblank
line_width  out  CNT_BITS  active pixels in last completed line
frame_lines  out  CNT_BITS  active lines in last completed frame
frame_count  out  16  completed frames since reset, wraps 0xFFFF->0
frame_done  out  1  one clk_sys pulse when a frame is latched

Behaviour:
- Reset (reset_n low at clk_sys edge): all outputs 0; pipeline registers 0; palette entry 0 = 24'h000000, all other entries = 24'hFFFFFF, matching legacy 1bpp black/white; armed flag cleared.
- Pipeline, advancing only on ce_pix:
  - Stage 1 registers pixel, hsync, vsync, hblank, vblank.
  - Stage 2 looks up the palette with the stage-1 index and registers the colour and the stage-1 sync/blank.
  - Latency: exactly 2 ce_pix-qualified clocks from input to vga_*; outputs hold between enables.
- de = ~(hblank|vblank) at stage 1. When de is 0, stage 2 loads 0 into vga_r/g/b regardless of palette.
- Palette writes:
  - Take effect on the clk_sys edge where pal_wr is high.
  - A stage-2 lookup on that same edge of the same entry returns the old value (read-before-write).
  - A write during reset is ignored.
- Measurement, using stage-1 samples on ce_pix edges only:
  - pix_cnt increments on each de sample, saturating at 2**CNT_BITS-1.
  - On the de 1->0 transition: line_width <= pix_cnt and line_cnt increments (saturating). pix_cnt clears.
  - On the stage-1 vsync 0->1 edge, first edge after reset: sets armed and clears line_cnt; no latch and no frame_done (partial frame).
  - On later vsync 0->1 edges: frame_lines <= line_cnt, frame_count increments, frame_done pulses high for exactly one clk_sys, line_cnt clears.
- Simultaneous de 1->0 and vsync 0->1 on the same sample: the line completes first, and frame_lines includes it.
- Lines with zero active pixels do not increment line_cnt and do not update line_width.
- Reset mid-frame: everything returns to reset values on that edge; the next vsync edge only re-arms.

Test Plan:
- Reset defaults: PIX_BITS=1, pixel=1 and de=1 for 2 ce_pix clocks after reset_n rises -> RGB=FFFFFF. Pixel=0 -> 000000 two ce_pix clocks later.
- Latency and ce gating: ce_pix every 4th clk, index pattern 0,1,0 -> colour changes exactly 2 enables after input; holds between enables; syncs shift identically.
- Palette: PIX_BITS=2, write entry 2=0x123456, feed index 2 with de=1 -> 0x123456. Write the same entry on the lookup edge -> old value on that edge, new value on the next. During blank -> 000000.
- Measurement: 3 frames of 160 active px × 128 active lines -> first vsync gives no frame_done. Then frame_lines=128, line_width=160, frame_count=2 with two 1-clk frame_done pulses.
- Boundaries:
  - 5000-px line with CNT_BITS=12 -> line_width=4095.
  - de fall coinciding with vsync rise -> line counted.
  - frame_count from 0xFFFF -> 0.
- Mid-frame reset_n low for 1 clk -> outputs and counters 0, palette restored; the next vsync edge arms only.
